fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction fetch stage with IF/ID pipeline register. It drives OPCODE into unit_control.
- Holds the program counter (PC) and an internal word-addressed instruction memory with a load port.
- Registers the fetched instruction and PC+4 into IF/ID.
- Supports stall (hold) and branch redirect with flush (bubble insertion).

Parameters:
IMEM_DEPTH, 256, number of 32-bit instruction words; power of two, >= 4.
RESET_PC, 32'h0000_0000, PC value after reset; bits [1:0] must be 0.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  synchronous active-low reset.
stall  input  1  hold PC and IF/ID contents.
branch_taken  input  1  redirect PC to branch_target and flush IF/ID.
branch_target  input  32  redirect address; bits [1:0] ignored (forced 0).
imem_we  input  1  instruction memory write enable.
imem_waddr  input  log2(IMEM_DEPTH)  word address for load.
imem_wdata  input  32  word to load.
pc  output  32  current PC (registered).
if_id_instr  output  32  registered instruction.
if_id_pc4  output  32  registered PC+4 of that instruction.
if_id_valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble.
OPCODE  output  6  equals if_id_instr[31:26]; feeds unit_control.
fetch_err  output  1  sticky: set when a fetch reads outside IMEM_DEPTH.

Behaviour:
- Reset, when rst_n=0 at a clock edge:
  - pc=RESET_PC.
  - if_id_instr=0, if_id_pc4=0, if_id_valid=0, fetch_err=0.
  - Memory contents are not cleared.
  - Reset dominates every other input, including mid-stall and mid-redirect.
- Fetch address: word index = pc[log2(IMEM_DEPTH)+1:2].
- In range: pc[31:log2(IMEM_DEPTH)+2] all zero.
  - Fetch word = mem[index]. Memory read is combinational from pc.
- Out of range:
  - Fetch word = 32'h0000_0000 (NOP).
  - fetch_err is set on the edge where that word is loaded into IF/ID.
- Per-edge priority when out of reset:
  1. branch_taken=1:
     - pc <= {branch_target[31:2],2'b00}.
     - IF/ID: instr=0, pc4=0, valid=0.
     - Overrides stall, so a flush during a stall still flushes.
  2. stall=1: pc, if_id_instr, if_id_pc4, if_id_valid and fetch_err all hold.
  3. Otherwise:
     - pc <= pc+4, mod 2^32; 32'hFFFF_FFFC wraps to 0.
     - if_id_instr <= fetch word; if_id_pc4 <= pc+4 (same wrap); if_id_valid <= 1.
- Latency:
  - Instruction at address A appears on if_id_instr one edge after pc==A with no stall and no branch.
  - After redirect: 1 bubble cycle, then the target instruction on the following edge. Redirect penalty is 1 cycle.
- OPCODE is combinational from the IF/ID register only; it never passes through from memory.
  - During a bubble OPCODE=6'b000000. Consumers must qualify with if_id_valid.
- Memory write:
  - Synchronous: mem[imem_waddr] <= imem_wdata when imem_we=1.
  - Writes are accepted during reset and during stall.
  - Same-edge write and fetch of the same word: IF/ID captures the old word; the new word is visible from the next cycle.
- fetch_err clears only on reset.
- No X on any output after the first reset edge.

Test Plan:
- Reset then sequential fetch:
  - Stimulus: load mem[0..3]=32'h0000_0020, 32'h8C01_0004, 32'hAC01_0008, 32'h1000_0002; release rst_n.
  - Required: pc steps 0,4,8,C,10.
  - Required: if_id_instr follows the loaded words one edge behind with if_id_valid=1.
  - Required: if_id_pc4 = 4,8,C,10; OPCODE = 00,23,2B,04.
- Stall hold: assert stall for 3 cycles while pc=8 -> pc stays 8; if_id_instr stays 32'h8C01_0004. On release, fetch resumes with 32'hAC01_0008.
- Branch redirect:
  - Stimulus: branch_taken=1 with branch_target=32'h0000_0006 while pc=C.
  - Required: next edge pc=4 (low bits forced 0) and if_id_valid=0, OPCODE=0.
  - Required: following edge if_id_instr=32'h8C01_0004, valid=1.
- Branch during stall: assert stall=1 and branch_taken=1 together -> redirect and flush occur; stall does not hold pc.
- Out-of-range fetch with IMEM_DEPTH=256:
  - Stimulus: branch to 32'h0000_0400.
  - Required: one edge later if_id_instr=0, valid=1, fetch_err=1.
  - Required: fetch_err stays 1 after returning in range, until rst_n=0.
- Write/fetch collision and reset mid-run:
  - Stimulus: write mem[2]=32'hDEAD_BEEF on the edge where pc=8.
  - Required: IF/ID gets the old word; the new word is visible on the next fetch of 8.
  - Stimulus: assert rst_n=0 during a stall.
  - Required: pc=RESET_PC, valid=0 on that edge.

Source files
------------

// File: rtl/fetch_stage_if.sv
// ============================================================================
// Module   : fetch_stage_if
// Purpose  : Control, load and IF/ID bundle of the instruction fetch stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fetch_stage_if #(
  parameter int IMEM_DEPTH = 256
);
  localparam int c_AW = $clog2(IMEM_DEPTH);

  logic              stall;
  logic              branch_taken;
  logic [31:0]       branch_target;
  logic              imem_we;
  logic [c_AW-1:0]   imem_waddr;
  logic [31:0]       imem_wdata;
  logic [31:0]       pc;
  logic [31:0]       if_id_instr;
  logic [31:0]       if_id_pc4;
  logic              if_id_valid;
  logic [5:0]        OPCODE;
  logic              fetch_err;

  modport master (
    output stall, branch_taken, branch_target, imem_we, imem_waddr, imem_wdata,
    input  pc, if_id_instr, if_id_pc4, if_id_valid, OPCODE, fetch_err
  );

  modport slave (
    input  stall, branch_taken, branch_target, imem_we, imem_waddr, imem_wdata,
    output pc, if_id_instr, if_id_pc4, if_id_valid, OPCODE, fetch_err
  );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Purpose  : PC, loadable instruction memory and IF/ID register with stall/flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  fetch_stage_if.slave   bus
);
  localparam int c_AW = $clog2(IMEM_DEPTH);

  logic [31:0] r_mem [IMEM_DEPTH];
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;
  logic        r_err;

  logic [31:0]     w_pc4;
  logic [31:0]     w_target;
  logic [c_AW-1:0] w_index;
  logic            w_in_range;
  logic [31:0]     w_fetch_word;

  assign w_pc4        = r_pc + 32'd4;
  assign w_target     = bus.branch_target & ~32'h0000_0003;
  assign w_index      = r_pc[c_AW+1:2];
  assign w_in_range   = (r_pc[31:c_AW+2] == '0);
  assign w_fetch_word = w_in_range ? r_mem[w_index] : 32'h0000_0000;

  // Memory is deliberately outside reset so programs can be loaded while held in reset.
  always_ff @(posedge clk) begin
    if (bus.imem_we) begin
      r_mem[bus.imem_waddr] <= bus.imem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_instr <= 32'h0;
      r_pc4   <= 32'h0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (bus.branch_taken) begin
      r_pc    <= w_target;
      r_instr <= 32'h0;
      r_pc4   <= 32'h0;
      r_valid <= 1'b0;
    end else if (!bus.stall) begin
      r_pc    <= w_pc4;
      r_instr <= w_fetch_word;
      r_pc4   <= w_pc4;
      r_valid <= 1'b1;
      if (!w_in_range) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.pc          = r_pc;
  assign bus.if_id_instr = r_instr;
  assign bus.if_id_pc4   = r_pc4;
  assign bus.if_id_valid = r_valid;
  assign bus.OPCODE      = r_instr[31:26];
  assign bus.fetch_err   = r_err;
endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed scoreboard bench for fetch_stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;
  localparam int c_DEPTH = 256;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  exp_t sb [$];

  fetch_stage_if #(.IMEM_DEPTH(c_DEPTH)) bus ();

  fetch_stage #(.IMEM_DEPTH(c_DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time bound");
    $fatal(1, "timeout");
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, queue the expected post-edge state, then compare.
  task automatic cyc(input string tag, input logic rn, input logic st, input logic br,
                     input logic [31:0] tgt, input logic we, input logic [7:0] wa,
                     input logic [31:0] wd, input logic [31:0] e_pc, input logic [31:0] e_instr,
                     input logic [31:0] e_pc4, input logic e_v, input logic e_err);
    exp_t e;
    exp_t got;
    logic [31:0] e_op;
    @(negedge clk);
    rst_n             = rn;
    bus.stall         = st;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    bus.imem_we       = we;
    bus.imem_waddr    = wa;
    bus.imem_wdata    = wd;
    e.pc = e_pc; e.instr = e_instr; e.pc4 = e_pc4; e.valid = e_v; e.err = e_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end
    if (sb.size() != 0) begin
      got  = sb.pop_front();
      e_op = {26'h0, got.instr[31:26]};
      chk32({tag, ".pc"},    bus.pc,                 got.pc);
      chk32({tag, ".instr"}, bus.if_id_instr,        got.instr);
      chk32({tag, ".pc4"},   bus.if_id_pc4,          got.pc4);
      chk32({tag, ".valid"}, {31'h0, bus.if_id_valid}, {31'h0, got.valid});
      chk32({tag, ".op"},    {26'h0, bus.OPCODE},    e_op);
      chk32({tag, ".err"},   {31'h0, bus.fetch_err}, {31'h0, got.err});
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 32'h0;
    bus.imem_we = 1'b0; bus.imem_waddr = '0; bus.imem_wdata = 32'h0;

    // Program load while held in reset
    cyc("rst0", 0, 0, 0, 0, 1, 8'd0, 32'h0000_0020, 32'h0, 32'h0, 32'h0, 0, 0);
    cyc("rst1", 0, 0, 0, 0, 1, 8'd1, 32'h8C01_0004, 32'h0, 32'h0, 32'h0, 0, 0);
    cyc("rst2", 0, 0, 0, 0, 1, 8'd2, 32'hAC01_0008, 32'h0, 32'h0, 32'h0, 0, 0);
    cyc("rst3", 0, 0, 0, 0, 1, 8'd3, 32'h1000_0002, 32'h0, 32'h0, 32'h0, 0, 0);
    cyc("rst4", 0, 0, 0, 0, 1, 8'd4, 32'h2002_0005, 32'h0, 32'h0, 32'h0, 0, 0);

    // Sequential fetch and stall hold at pc=8
    cyc("seq0",  1, 0, 0, 0, 0, 0, 0, 32'h4, 32'h0000_0020, 32'h4, 1, 0);
    cyc("seq1",  1, 0, 0, 0, 0, 0, 0, 32'h8, 32'h8C01_0004, 32'h8, 1, 0);
    cyc("stl0",  1, 1, 0, 0, 0, 0, 0, 32'h8, 32'h8C01_0004, 32'h8, 1, 0);
    cyc("stl1",  1, 1, 0, 0, 0, 0, 0, 32'h8, 32'h8C01_0004, 32'h8, 1, 0);
    cyc("stl2",  1, 1, 0, 0, 0, 0, 0, 32'h8, 32'h8C01_0004, 32'h8, 1, 0);
    cyc("seq2",  1, 0, 0, 0, 0, 0, 0, 32'hC, 32'hAC01_0008, 32'hC, 1, 0);

    // Redirect from pc=C to 6 (forced to 4), one bubble
    cyc("br0",   1, 0, 1, 32'h6, 0, 0, 0, 32'h4, 32'h0, 32'h0, 0, 0);
    cyc("br1",   1, 0, 0, 0, 0, 0, 0, 32'h8,  32'h8C01_0004, 32'h8,  1, 0);
    cyc("br2",   1, 0, 0, 0, 0, 0, 0, 32'hC,  32'hAC01_0008, 32'hC,  1, 0);
    cyc("br3",   1, 0, 0, 0, 0, 0, 0, 32'h10, 32'h1000_0002, 32'h10, 1, 0);
    cyc("br4",   1, 0, 0, 0, 0, 0, 0, 32'h14, 32'h2002_0005, 32'h14, 1, 0);

    // Branch overrides stall
    cyc("bst0",  1, 1, 1, 32'h8, 0, 0, 0, 32'h8, 32'h0, 32'h0, 0, 0);
    cyc("bst1",  1, 0, 0, 0, 0, 0, 0, 32'hC, 32'hAC01_0008, 32'hC, 1, 0);

    // Out-of-range fetch sets sticky error
    cyc("oor0",  1, 0, 1, 32'h400, 0, 0, 0, 32'h400, 32'h0, 32'h0, 0, 0);
    cyc("oor1",  1, 0, 0, 0, 0, 0, 0, 32'h404, 32'h0, 32'h404, 1, 1);
    cyc("oor2",  1, 0, 1, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1);
    cyc("oor3",  1, 0, 0, 0, 0, 0, 0, 32'h4, 32'h0000_0020, 32'h4, 1, 1);
    cyc("oor4",  1, 0, 0, 0, 0, 0, 0, 32'h8, 32'h8C01_0004, 32'h8, 1, 1);

    // Same-edge write and fetch of word 2: old word captured
    cyc("col0",  1, 0, 0, 0, 1, 8'd2, 32'hDEAD_BEEF, 32'hC, 32'hAC01_0008, 32'hC, 1, 1);
    cyc("col1",  1, 0, 1, 32'h8, 0, 0, 0, 32'h8, 32'h0, 32'h0, 0, 1);
    cyc("col2",  1, 0, 0, 0, 0, 0, 0, 32'hC, 32'hDEAD_BEEF, 32'hC, 1, 1);

    // Reset dominates stall and branch; memory survives reset
    cyc("rs0",   1, 1, 0, 0, 0, 0, 0, 32'hC, 32'hDEAD_BEEF, 32'hC, 1, 1);
    cyc("rs1",   0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
    cyc("rs2",   0, 0, 1, 32'h40, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0);
    cyc("rs3",   1, 0, 0, 0, 0, 0, 0, 32'h4, 32'h0000_0020, 32'h4, 1, 0);

    // PC wrap at top of address space
    cyc("wrp0",  1, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 0);
    cyc("wrp1",  1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 1);
    cyc("wrp2",  1, 0, 0, 0, 0, 0, 0, 32'h4, 32'h0000_0020, 32'h4, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
